// File: rtl/note_parser.sv
// Parses a stream of character-ROM addresses ("<letter><space|#><digit>") into a 6-bit note index 1..63.
// Latency: out_valid rises on the clk edge after the octave character is accepted; one err pulse per rejection.
// Backpressure: in_ready drops while a note waits in S_OUT; out_valid/out_note hold until out_ready.
// Optional: define NOTE_PARSER_TIMEOUT_EN to abort a partial note after TIMEOUT_CYCLES idle cycles.
module note_parser #(
   parameter logic [23:0] TIMEOUT_CYCLES = 24'd10_000_000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       in_valid,
   output logic       in_ready,
   input  logic [8:0] in_addr,
   output logic       out_valid,
   input  logic       out_ready,
   output logic [5:0] out_note,
   output logic       err,
   output logic [7:0] err_count
);

   typedef enum logic [1:0] {
      S_LETTER = 2'd0,
      S_ACC    = 2'd1,
      S_OCT    = 2'd2,
      S_OUT    = 2'd3
   } state_t;

   state_t     r_state;
   state_t     w_state_nxt;
   logic [2:0] r_letter;
   logic [2:0] w_letter_nxt;
   logic       r_sharp;
   logic       w_sharp_nxt;
   logic [5:0] r_out_note;
   logic       r_out_valid;
   logic       r_err;
   logic [7:0] r_err_count;

   logic       w_in_xfer;
   logic       w_fmt_ok;
   logic [5:0] w_code;
   logic       w_is_letter;
   logic       w_is_space;
   logic       w_is_hash;
   logic       w_is_digit;
   logic       w_hash_ok;
   logic [2:0] w_oct_m1;
   logic [3:0] w_base_off;
   logic [3:0] w_off;
   logic [6:0] w_note;
   logic       w_err_set;
   logic       w_load_note;
   logic       w_timeout;

   assign in_ready  = (r_state != S_OUT);
   assign out_valid = r_out_valid;
   assign out_note  = r_out_note;
   assign err       = r_err;
   assign err_count = r_err_count;

   assign w_in_xfer = in_valid && in_ready;

   // Character classification: the address must be 8-aligned, the code sits in the upper six bits.
   assign w_fmt_ok    = (in_addr[2:0] == 3'd0);
   assign w_code      = in_addr[8:3];
   assign w_is_letter = w_fmt_ok && (w_code >= 6'd1)  && (w_code <= 6'd7);
   assign w_is_space  = w_fmt_ok && (w_code == 6'h20);
   assign w_is_hash   = w_fmt_ok && (w_code == 6'h23);
   assign w_is_digit  = w_fmt_ok && (w_code >= 6'h31) && (w_code <= 6'h36);
   assign w_oct_m1    = w_code[2:0] - 3'd1;

   // B and E have no sharp; letter index 2 is B, 5 is E.
   assign w_hash_ok = (r_letter != 3'd2) && (r_letter != 3'd5);

   // Semitone offset of the natural letter counted from A.
   always_comb begin
      w_base_off = 4'd0;
      case (r_letter)
         3'd1:    w_base_off = 4'd0;   // A
         3'd2:    w_base_off = 4'd2;   // B
         3'd3:    w_base_off = 4'd3;   // C
         3'd4:    w_base_off = 4'd5;   // D
         3'd5:    w_base_off = 4'd7;   // E
         3'd6:    w_base_off = 4'd8;   // F
         3'd7:    w_base_off = 4'd10;  // G
         default: w_base_off = 4'd0;
      endcase
   end

   // Seven bits so that out-of-range notes (up to 72) can be detected before truncation.
   assign w_off  = w_base_off + {3'd0, r_sharp};
   assign w_note = ({4'd0, w_oct_m1} * 7'd12) + {3'd0, w_off} + 7'd1;

`ifdef NOTE_PARSER_TIMEOUT_EN
   logic [23:0] r_idle;
   logic        w_idle_run;

   assign w_idle_run = ((r_state == S_ACC) || (r_state == S_OCT)) && !w_in_xfer;
   assign w_timeout  = w_idle_run && (r_idle == (TIMEOUT_CYCLES - 24'd1));

   // Idle counter: runs only while a note is partially entered and nothing arrives.
   always_ff @(posedge clk) begin
      if (!rst_n || !w_idle_run || w_timeout) begin
         r_idle <= 24'd0;
      end else begin
         r_idle <= r_idle + 24'd1;
      end
   end
`else
   // No abort in this build; the parameter is referenced only to keep one interface for both builds.
   assign w_timeout = 1'b0 && (TIMEOUT_CYCLES != 24'd0);
`endif

   // Next-state and datapath control for the three-character grammar.
   always_comb begin
      w_state_nxt  = r_state;
      w_letter_nxt = r_letter;
      w_sharp_nxt  = r_sharp;
      w_err_set    = 1'b0;
      w_load_note  = 1'b0;
      case (r_state)
         S_LETTER: begin
            if (w_in_xfer) begin
               if (w_is_letter) begin
                  w_letter_nxt = w_code[2:0];
                  w_state_nxt  = S_ACC;
               end else if (!w_is_space) begin
                  w_err_set = 1'b1;
               end
            end
         end
         S_ACC: begin
            if (w_in_xfer) begin
               if (w_is_space) begin
                  w_sharp_nxt = 1'b0;
                  w_state_nxt = S_OCT;
               end else if (w_is_hash && w_hash_ok) begin
                  w_sharp_nxt = 1'b1;
                  w_state_nxt = S_OCT;
               end else begin
                  w_err_set   = 1'b1;
                  w_state_nxt = S_LETTER;
               end
            end
         end
         S_OCT: begin
            if (w_in_xfer) begin
               if (w_is_digit && (w_note <= 7'd63)) begin
                  w_load_note = 1'b1;
                  w_state_nxt = S_OUT;
               end else begin
                  w_err_set   = 1'b1;
                  w_state_nxt = S_LETTER;
               end
            end
         end
         S_OUT: begin
            if (out_ready) begin
               w_state_nxt = S_LETTER;
            end
         end
         default: w_state_nxt = S_LETTER;
      endcase
      if (w_timeout) begin
         w_err_set   = 1'b1;
         w_state_nxt = S_LETTER;
      end
   end

   // State, partial-note, output and error registers.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state     <= S_LETTER;
         r_letter    <= 3'd0;
         r_sharp     <= 1'b0;
         r_out_note  <= 6'd0;
         r_out_valid <= 1'b0;
         r_err       <= 1'b0;
         r_err_count <= 8'd0;
      end else begin
         r_state     <= w_state_nxt;
         r_letter    <= w_letter_nxt;
         r_sharp     <= w_sharp_nxt;
         r_out_valid <= (w_state_nxt == S_OUT);
         r_err       <= w_err_set;
         if (w_load_note) begin
            r_out_note <= w_note[5:0];
         end
         if (w_err_set && (r_err_count != 8'hFF)) begin
            r_err_count <= r_err_count + 8'd1;
         end
      end
   end

endmodule

// File: tb/tb_note_parser.sv
// Directed bench for note_parser: reset, note decode, rejections, backpressure, back-to-back, saturation.
module tb_note_parser;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       in_valid;
   logic       in_ready;
   logic [8:0] in_addr;
   logic       out_valid;
   logic       out_ready;
   logic [5:0] out_note;
   logic       err;
   logic [7:0] err_count;

   int n_pass  = 0;
   int n_total = 0;
   int cyc     = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   note_parser #(.TIMEOUT_CYCLES(24'd16)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_addr   (in_addr),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_note  (out_note),
      .err       (err),
      .err_count (err_count)
   );

   // Presents one character and returns #1 after the edge that takes it.
   task automatic send_char(input logic [8:0] a);
      int w = 0;
      while (!in_ready && w < 100) begin
         @(posedge clk); #1;
         w++;
      end
      if (!in_ready) begin
         n_total++;
         $display("FAIL send_char_ready: in_ready=%b required 1 after %0d cycles", in_ready, w);
      end
      in_valid = 1'b1;
      in_addr  = a;
      @(posedge clk); #1;
      in_valid = 1'b0;
      in_addr  = 9'd0;
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      @(posedge clk); @(posedge clk); #1;
      n_total++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", out_valid); else n_pass++;
      n_total++; if (out_note !== 6'd0) $display("FAIL reset_out_note: got %0d want 0", out_note); else n_pass++;
      n_total++; if (err !== 1'b0) $display("FAIL reset_err: got %b want 0", err); else n_pass++;
      n_total++; if (err_count !== 8'd0) $display("FAIL reset_err_count: got %0d want 0", err_count); else n_pass++;
      n_total++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", in_ready); else n_pass++;
      rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_basic;
      out_ready = 1'b1;
      send_char(9'h008); send_char(9'h100); send_char(9'h188);
      n_total++; if (out_valid !== 1'b1) $display("FAIL basic_valid: got %b want 1", out_valid); else n_pass++;
      n_total++; if (out_note !== 6'd1) $display("FAIL basic_note: got %0d want 1", out_note); else n_pass++;
      n_total++; if (err !== 1'b0) $display("FAIL basic_err: got %b want 0", err); else n_pass++;
      @(posedge clk); #1;
      n_total++; if (out_valid !== 1'b0) $display("FAIL basic_valid_drop: got %b want 0", out_valid); else n_pass++;
      n_total++; if (in_ready !== 1'b1) $display("FAIL basic_in_ready: got %b want 1", in_ready); else n_pass++;
   endtask

   task automatic test_sharp_and_max;
      send_char(9'h018); send_char(9'h118); send_char(9'h190);
      n_total++; if (out_valid !== 1'b1 || out_note !== 6'd17)
         $display("FAIL csharp2_note: got valid=%b note=%0d want valid=1 note=17", out_valid, out_note); else n_pass++;
      send_char(9'h010); send_char(9'h100); send_char(9'h1B0);
      n_total++; if (out_valid !== 1'b1 || out_note !== 6'd63)
         $display("FAIL b6_note: got valid=%b note=%0d want valid=1 note=63", out_valid, out_note); else n_pass++;
      n_total++; if (err_count !== 8'd0) $display("FAIL notes_err_count: got %0d want 0", err_count); else n_pass++;
      @(posedge clk); #1;
   endtask

   task automatic test_errors;
      send_char(9'h038); send_char(9'h118); send_char(9'h1B0);
      n_total++; if (err !== 1'b1) $display("FAIL gsharp6_err: got %b want 1", err); else n_pass++;
      n_total++; if (out_valid !== 1'b0) $display("FAIL gsharp6_valid: got %b want 0", out_valid); else n_pass++;
      n_total++; if (err_count !== 8'd1) $display("FAIL gsharp6_count: got %0d want 1", err_count); else n_pass++;
      @(posedge clk); #1;
      n_total++; if (err !== 1'b0) $display("FAIL err_one_cycle: got %b want 0", err); else n_pass++;
      send_char(9'h028); send_char(9'h118);
      n_total++; if (err !== 1'b1 || err_count !== 8'd2)
         $display("FAIL esharp_err: got err=%b count=%0d want err=1 count=2", err, err_count); else n_pass++;
      send_char(9'h188);
      n_total++; if (err !== 1'b1 || err_count !== 8'd3)
         $display("FAIL digit_in_letter: got err=%b count=%0d want err=1 count=3", err, err_count); else n_pass++;
      send_char(9'h100);
      n_total++; if (err !== 1'b0 || err_count !== 8'd3)
         $display("FAIL space_ignored: got err=%b count=%0d want err=0 count=3", err, err_count); else n_pass++;
      send_char(9'h009);
      n_total++; if (err !== 1'b1 || err_count !== 8'd4)
         $display("FAIL misaligned: got err=%b count=%0d want err=1 count=4", err, err_count); else n_pass++;
      send_char(9'h018); send_char(9'h100); send_char(9'h188);
      n_total++; if (out_valid !== 1'b1 || out_note !== 6'd4)
         $display("FAIL recover_c1: got valid=%b note=%0d want valid=1 note=4", out_valid, out_note); else n_pass++;
      @(posedge clk); #1;
   endtask

   task automatic test_backpressure;
      logic held;
      out_ready = 1'b0;
      send_char(9'h020); send_char(9'h100); send_char(9'h198);
      n_total++; if (out_valid !== 1'b1 || out_note !== 6'd30)
         $display("FAIL d3_note: got valid=%b note=%0d want valid=1 note=30", out_valid, out_note); else n_pass++;
      held = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(posedge clk); #1;
         if (out_valid !== 1'b1 || out_note !== 6'd30 || in_ready !== 1'b0) held = 1'b0;
      end
      n_total++; if (held !== 1'b1)
         $display("FAIL hold_stable: got valid=%b note=%0d in_ready=%b want 1/30/0", out_valid, out_note, in_ready); else n_pass++;
      out_ready = 1'b1;
      @(posedge clk); #1;
      n_total++; if (out_valid !== 1'b0 || in_ready !== 1'b1)
         $display("FAIL release: got valid=%b in_ready=%b want 0/1", out_valid, in_ready); else n_pass++;
   endtask

   task automatic test_back_to_back;
      int t0;
      out_ready = 1'b1;
      send_char(9'h030); send_char(9'h118); send_char(9'h1A0);
      t0 = cyc;
      n_total++; if (out_valid !== 1'b1 || out_note !== 6'd46)
         $display("FAIL fsharp4_note: got valid=%b note=%0d want valid=1 note=46", out_valid, out_note); else n_pass++;
      send_char(9'h008); send_char(9'h100); send_char(9'h188);
      n_total++; if (out_valid !== 1'b1 || out_note !== 6'd1)
         $display("FAIL b2b_note: got valid=%b note=%0d want valid=1 note=1", out_valid, out_note); else n_pass++;
      n_total++; if (cyc - t0 !== 4) $display("FAIL b2b_period: got %0d want 4", cyc - t0); else n_pass++;
      @(posedge clk); #1;
   endtask

   task automatic test_reset_midseq;
      send_char(9'h008); send_char(9'h100);
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      n_total++; if (err !== 1'b0 || err_count !== 8'd0 || out_valid !== 1'b0)
         $display("FAIL midseq_reset: got err=%b count=%0d valid=%b want 0/0/0", err, err_count, out_valid); else n_pass++;
      send_char(9'h188);
      n_total++; if (err !== 1'b1 || out_valid !== 1'b0 || err_count !== 8'd1)
         $display("FAIL midseq_digit: got err=%b valid=%b count=%0d want 1/0/1", err, out_valid, err_count); else n_pass++;
   endtask

   task automatic test_saturation;
      for (int i = 0; i < 260; i++) send_char(9'h009);
      n_total++; if (err_count !== 8'd255) $display("FAIL err_saturate: got %0d want 255", err_count); else n_pass++;
      n_total++; if (err !== 1'b1) $display("FAIL err_at_saturate: got %b want 1", err); else n_pass++;
      @(posedge clk); #1;
   endtask

`ifdef NOTE_PARSER_TIMEOUT_EN
   task automatic test_timeout;
      logic early;
      send_char(9'h008);
      early = 1'b0;
      for (int i = 0; i < 15; i++) begin
         @(posedge clk); #1;
         if (err !== 1'b0) early = 1'b1;
      end
      n_total++; if (early !== 1'b0) $display("FAIL timeout_early: err seen before 16 idle cycles"); else n_pass++;
      @(posedge clk); #1;
      n_total++; if (err !== 1'b1 || in_ready !== 1'b1)
         $display("FAIL timeout_err: got err=%b in_ready=%b want 1/1", err, in_ready); else n_pass++;
      send_char(9'h100);
      n_total++; if (err !== 1'b0) $display("FAIL timeout_space: got err=%b want 0", err); else n_pass++;
   endtask
`endif

   initial begin
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_addr   = 9'd0;
      out_ready = 1'b1;
      test_reset();
      test_basic();
      test_sharp_and_max();
      test_errors();
      test_backpressure();
      test_back_to_back();
      test_reset_midseq();
      test_saturation();
`ifdef NOTE_PARSER_TIMEOUT_EN
      test_timeout();
`endif
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/note_parser.md
Name: note_parser

Overview:
- Inverse of the note-to-character lookup: accepts a stream of 9-bit character-ROM addresses and assembles them into a 6-bit note index (1..63).
- Each note is spelled as three characters: a letter, then a space or hash, then an octave digit. Example: "C# 2" sent as LETTER_C, SYMBOL_HASH, NUMBER_2 gives note 17.
- Sits between the text/keypad entry path and the note player.
- Flags malformed sequences and keeps an error count.

Parameters:
- TIMEOUT_CYCLES, 24'd10_000_000: idle cycles allowed between characters of one note before the partial note is aborted. Used only with NOTE_PARSER_TIMEOUT_EN.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  synchronous active-low reset, sampled on the rising edge of clk.
- in_valid  input  1  in_addr is valid this cycle.
- in_ready  output  1  parser can accept a character.
- in_addr  input  9  character-ROM address (char code * 8).
- out_valid  output  1  out_note is valid; held until accepted.
- out_ready  input  1  downstream accepts out_note.
- out_note  output  6  note index, 1..63.
- err  output  1  one-cycle pulse on a rejected character or sequence.
- err_count  output  8  saturating count of err pulses.

Behaviour:
- Reset (rst_n low at a clk edge):
  - state=S_LETTER, out_valid=0, out_note=0, err=0, err_count=0.
  - Partial letter/sharp registers are cleared.
  - Reset mid-sequence discards the partial note with no err.
- Transfer rules:
  - An input character transfers when in_valid && in_ready.
  - An output note transfers when out_valid && out_ready.
  - in_ready = (state != S_OUT).
- Decode of in_addr:
  - in_addr[2:0] != 0 is invalid.
  - code = in_addr[8:3].
  - Letters: A..G = codes 1..7.
  - Space = 0x20, hash = 0x23.
  - Digits: 1..6 = codes 0x31..0x36.
  - Everything else is invalid.
- FSM:
  - S_LETTER:
    - Space is ignored (word separator), no err.
    - A letter latches its index and moves to S_ACC.
    - Any other character pulses err and stays in S_LETTER.
  - S_ACC:
    - Space sets sharp=0; hash sets sharp=1; both move to S_OCT.
    - Hash after B or E is invalid.
    - Any invalid character pulses err and returns to S_LETTER.
  - S_OCT:
    - A digit 1..6 computes note = (oct-1)*12 + off + 1.
    - off: A=0, A#=1, B=2, C=3, C#=4, D=5, D#=6, E=7, F=8, F#=9, G=10, G#=11.
    - If note <= 63: register out_note, set out_valid on the next edge, go to S_OUT.
    - Otherwise (octave 6 with off > 2): pulse err and return to S_LETTER.
    - A non-digit pulses err and returns to S_LETTER.
  - S_OUT:
    - out_valid=1 with out_note stable.
    - When out_ready is high: out_valid=0 on the next edge, go to S_LETTER.
    - Input is stalled (in_ready=0) while in S_OUT.
- Timing:
  - Latency: out_valid rises on the clk edge after the octave character is accepted.
  - Minimum note period: 4 cycles (3 characters plus 1 output cycle with out_ready held high).
- Arithmetic:
  - Compute in 7 bits: (oct-1)*12 is at most 60, plus off at most 11, plus 1, gives at most 72.
  - Compare against 63 before truncating to 6 bits.
- err and err_count:
  - err is registered: it rises the cycle after the offending transfer and lasts exactly 1 cycle.
  - err_count increments with each err and saturates at 255.
  - A rejected character is consumed, never replayed.

Optional Feature:
- Macro: NOTE_PARSER_TIMEOUT_EN.
- Defined:
  - A 24-bit idle counter runs while state is S_ACC or S_OCT and no input transfer occurs.
  - Any input transfer clears the counter.
  - At TIMEOUT_CYCLES the partial note is aborted: state returns to S_LETTER and err pulses once (counted).
  - The counter is cleared in S_LETTER and S_OUT.
- Undefined: no counter; a partial note waits indefinitely.

Test Plan:
- Send 0x008, 0x100, 0x188 with out_ready=1 -> out_valid pulse with out_note=1, err=0.
- Send 0x018, 0x118, 0x190 -> out_note=17; then 0x010, 0x100, 0x1B0 -> out_note=63.
- Send 0x038, 0x118, 0x1B0 (G#6) -> err pulse, err_count=1, no out_valid; then 0x028, 0x118 (E#) -> err pulse, err_count=2.
- Hold out_ready=0 after a valid note -> out_valid and out_note stay stable and in_ready=0 for 20 cycles; raise out_ready -> one transfer, then in_ready=1.
- Send 0x008, 0x100, then assert rst_n=0 for 1 cycle, then 0x188 -> err pulse (digit arriving in S_LETTER), no note output, err_count=1 after the reset.
- With NOTE_PARSER_TIMEOUT_EN and TIMEOUT_CYCLES=16: send 0x008, then idle 16 cycles -> err pulse, state S_LETTER; a following 0x100 is ignored with no err.
